// File: rtl/ball_motion.sv
// Ball motion engine: steps the ball once per frame tick, bounces off
// the left/right/top walls, latches collision flips, reports bottom misses.
//
// Ports:
//   clk, resetn           clock, synchronous active-low reset
//   tick, pause           move strobe (one per frame), motion hold
//   load, load_x/y/dx/dy  serve: position and direction, enter RUN
//   step_x, step_y        pixels moved per tick on each axis
//   flip_x, flip_y        collision direction-reversal requests (sticky)
//   x, y, dir_x, dir_y    ball position (top-left) and direction
//   wall_hit, miss        one-cycle event pulses
//   running               high while the ball is in play
module ball_motion #(
    parameter int XW        = 10,
    parameter int YW        = 10,
    parameter int STEP_W    = 3,
    parameter int X_MAX     = 639,
    parameter int Y_MAX     = 479,
    parameter int BALL_SIZE = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              tick,
    input  logic              pause,
    input  logic              load,
    input  logic [XW-1:0]     load_x,
    input  logic [YW-1:0]     load_y,
    input  logic              load_dx,
    input  logic              load_dy,
    input  logic [STEP_W-1:0] step_x,
    input  logic [STEP_W-1:0] step_y,
    input  logic              flip_x,
    input  logic              flip_y,
    output logic [XW-1:0]     x,
    output logic [YW-1:0]     y,
    output logic              dir_x,
    output logic              dir_y,
    output logic              wall_hit,
    output logic              miss,
    output logic              running
);

    // One extra bit so position + step never wraps before the limit test.
    localparam logic [XW:0] XLIM = (XW+1)'(X_MAX - BALL_SIZE + 1);
    localparam logic [YW:0] YLIM = (YW+1)'(Y_MAX - BALL_SIZE + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DEAD
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [XW-1:0]   x_n;
    logic [YW-1:0]   y_n;
    logic            dir_x_n;
    logic            dir_y_n;
    logic            wall_n;
    logic            miss_n;
    logic            pend_x;
    logic            pend_y;
    logic            pend_x_n;
    logic            pend_y_n;

    logic            move;
    logic            eff_x;
    logic            eff_y;
    logic [XW:0]     stp_x;
    logic [YW:0]     stp_y;
    logic [XW:0]     sum_x;
    logic [YW:0]     sum_y;

    assign running = (state == S_RUN);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= S_IDLE;
            x        <= '0;
            y        <= '0;
            dir_x    <= 1'b1;
            dir_y    <= 1'b0;
            wall_hit <= 1'b0;
            miss     <= 1'b0;
            pend_x   <= 1'b0;
            pend_y   <= 1'b0;
        end else begin
            state    <= state_n;
            x        <= x_n;
            y        <= y_n;
            dir_x    <= dir_x_n;
            dir_y    <= dir_y_n;
            wall_hit <= wall_n;
            miss     <= miss_n;
            pend_x   <= pend_x_n;
            pend_y   <= pend_y_n;
        end
    end

    always_comb begin
        state_n  = state;
        x_n      = x;
        y_n      = y;
        dir_x_n  = dir_x;
        dir_y_n  = dir_y;
        wall_n   = 1'b0;
        miss_n   = 1'b0;
        pend_x_n = pend_x | flip_x;
        pend_y_n = pend_y | flip_y;

        move  = (state == S_RUN) && tick && !pause;
        // Flip is applied first; the wall test then uses the new direction.
        eff_x = dir_x ^ (pend_x | flip_x);
        eff_y = dir_y ^ (pend_y | flip_y);
        stp_x = (XW+1)'(step_x);
        stp_y = (YW+1)'(step_y);
        sum_x = {1'b0, x} + stp_x;
        sum_y = {1'b0, y} + stp_y;

        if (load) begin
            x_n      = ({1'b0, load_x} > XLIM) ? XLIM[XW-1:0] : load_x;
            y_n      = ({1'b0, load_y} > YLIM) ? YLIM[YW-1:0] : load_y;
            dir_x_n  = load_dx;
            dir_y_n  = load_dy;
            pend_x_n = 1'b0;
            pend_y_n = 1'b0;
            state_n  = S_RUN;
        end else if (move) begin
            pend_x_n = 1'b0;
            pend_y_n = 1'b0;
            dir_x_n  = eff_x;
            dir_y_n  = eff_y;

            if (step_x != '0) begin
                if (eff_x) begin
                    if (sum_x >= XLIM) begin
                        x_n     = XLIM[XW-1:0];
                        dir_x_n = 1'b0;
                        wall_n  = 1'b1;
                    end else begin
                        x_n = sum_x[XW-1:0];
                    end
                end else begin
                    if ({1'b0, x} <= stp_x) begin
                        x_n     = '0;
                        dir_x_n = 1'b1;
                        wall_n  = 1'b1;
                    end else begin
                        x_n = x - stp_x[XW-1:0];
                    end
                end
            end

            if (step_y != '0) begin
                if (eff_y) begin
                    // Bottom edge: the ball is lost, direction kept.
                    if (sum_y >= YLIM) begin
                        y_n     = YLIM[YW-1:0];
                        miss_n  = 1'b1;
                        state_n = S_DEAD;
                    end else begin
                        y_n = sum_y[YW-1:0];
                    end
                end else begin
                    if ({1'b0, y} <= stp_y) begin
                        y_n     = '0;
                        dir_y_n = 1'b1;
                        wall_n  = 1'b1;
                    end else begin
                        y_n = y - stp_y[YW-1:0];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ball_motion.sv
// Directed bench for ball_motion: integer reference model compared every
// cycle, plus literal expectations for the serve/bounce/miss scenarios.
module tb_ball_motion;

    localparam int XLIM = 632;
    localparam int YLIM = 472;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       tick = 1'b0;
    logic       pause = 1'b0;
    logic       load = 1'b0;
    logic [9:0] load_x = '0;
    logic [9:0] load_y = '0;
    logic       load_dx = 1'b0;
    logic       load_dy = 1'b0;
    logic [2:0] step_x = '0;
    logic [2:0] step_y = '0;
    logic       flip_x = 1'b0;
    logic       flip_y = 1'b0;
    logic [9:0] x;
    logic [9:0] y;
    logic       dir_x;
    logic       dir_y;
    logic       wall_hit;
    logic       miss;
    logic       running;

    ball_motion dut (
        .clk(clk), .resetn(resetn), .tick(tick), .pause(pause),
        .load(load), .load_x(load_x), .load_y(load_y),
        .load_dx(load_dx), .load_dy(load_dy),
        .step_x(step_x), .step_y(step_y),
        .flip_x(flip_x), .flip_y(flip_y),
        .x(x), .y(y), .dir_x(dir_x), .dir_y(dir_y),
        .wall_hit(wall_hit), .miss(miss), .running(running)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference model: ball state as plain integers and flags.
    int mx, my, ex, ey, sx, sy;
    bit mdx, mdy, mwall, mmiss, alive, mpx, mpy;

    always @(posedge clk) begin
        mwall = 0;
        mmiss = 0;
        if (!resetn) begin
            mx = 0; my = 0; mdx = 1; mdy = 0;
            alive = 0; mpx = 0; mpy = 0;
        end else if (load) begin
            mx = (int'(load_x) > XLIM) ? XLIM : int'(load_x);
            my = (int'(load_y) > YLIM) ? YLIM : int'(load_y);
            mdx = load_dx; mdy = load_dy;
            mpx = 0; mpy = 0; alive = 1;
        end else if (alive && tick && !pause) begin
            ex = (mdx ^ (mpx | flip_x)) ? 1 : -1;
            ey = (mdy ^ (mpy | flip_y)) ? 1 : -1;
            mpx = 0; mpy = 0;
            sx = int'(step_x); sy = int'(step_y);
            mdx = (ex > 0); mdy = (ey > 0);
            if (sx > 0) begin
                mx = mx + ex * sx;
                if (mx >= XLIM) begin mx = XLIM; mdx = 0; mwall = 1; end
                if (mx <= 0)    begin mx = 0;    mdx = 1; mwall = 1; end
            end
            if (sy > 0) begin
                my = my + ey * sy;
                if (my >= YLIM) begin my = YLIM; mmiss = 1; alive = 0; end
                if (my <= 0)    begin my = 0;    mdy = 1; mwall = 1; end
            end
        end else begin
            mpx = mpx | flip_x;
            mpy = mpy | flip_y;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_x", 32'(x), 32'(mx));
            chk("m_y", 32'(y), 32'(my));
            chk("m_dir_x", 32'(dir_x), 32'(mdx));
            chk("m_dir_y", 32'(dir_y), 32'(mdy));
            chk("m_wall_hit", 32'(wall_hit), 32'(mwall));
            chk("m_miss", 32'(miss), 32'(mmiss));
            chk("m_running", 32'(running), 32'(alive));
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input int lx, input int ly,
                           input bit dx, input bit dy);
        load_x = 10'(lx); load_y = 10'(ly);
        load_dx = dx; load_dy = dy;
        load = 1; cyc(); load = 0;
    endtask

    task automatic do_tick(input int n);
        repeat (n) begin
            tick = 1; cyc(); tick = 0;
        end
    endtask

    initial begin
        cyc(1);
        cmp_en = 1;
        cyc(1);
        chk("rst_x", 32'(x), 0);
        chk("rst_dir_x", 32'(dir_x), 1);
        chk("rst_running", 32'(running), 0);
        resetn = 1;
        step_x = 3; step_y = 2;
        do_tick(5);
        chk("idle_x", 32'(x), 0);
        chk("idle_y", 32'(y), 0);

        do_load(100, 200, 1, 0);
        chk("serve_running", 32'(running), 1);
        do_tick(4);
        chk("run_x", 32'(x), 112);
        chk("run_y", 32'(y), 192);

        step_x = 4; step_y = 2;
        do_load(630, 50, 1, 1);
        do_tick(1);
        chk("rwall_x", 32'(x), 632);
        chk("rwall_dir", 32'(dir_x), 0);
        chk("rwall_hit", 32'(wall_hit), 1);
        cyc();
        chk("rwall_pulse", 32'(wall_hit), 0);
        do_tick(1);
        chk("rwall_back", 32'(x), 628);

        step_x = 3; step_y = 3;
        do_load(2, 1, 0, 0);
        do_tick(1);
        chk("corner_x", 32'(x), 0);
        chk("corner_y", 32'(y), 0);
        chk("corner_dirs", 32'({dir_x, dir_y}), 3);
        chk("corner_hit", 32'(wall_hit), 1);

        step_x = 3; step_y = 1;
        do_load(3, 100, 0, 0);
        do_tick(1);
        chk("lwall_exact", 32'(x), 0);
        chk("lwall_y", 32'(y), 99);

        step_x = 1; step_y = 4;
        do_load(300, 470, 1, 1);
        do_tick(1);
        chk("miss_y", 32'(y), 472);
        chk("miss_pulse", 32'(miss), 1);
        chk("miss_running", 32'(running), 0);
        cyc();
        chk("miss_clear", 32'(miss), 0);
        do_tick(3);
        chk("dead_hold", 32'(y), 472);
        do_load(300, 100, 1, 0);
        chk("reserve", 32'(running), 1);

        step_x = 3; step_y = 2;
        do_load(300, 200, 1, 1);
        flip_y = 1; cyc(); flip_y = 0;
        cyc();
        do_tick(1);
        chk("flip_y", 32'(y), 198);
        chk("flip_dir", 32'(dir_y), 0);
        do_tick(1);
        chk("flip_used", 32'(y), 196);
        flip_x = 1; cyc(); flip_x = 0;
        pause = 1; tick = 1; cyc(); tick = 0; pause = 0;
        chk("pause_x", 32'(x), 306);
        do_tick(1);
        chk("pend_x", 32'(x), 303);
        chk("pend_dir", 32'(dir_x), 0);

        step_x = 0;
        flip_x = 1; tick = 1; cyc(); flip_x = 0; tick = 0;
        chk("step0_x", 32'(x), 303);
        chk("step0_dir", 32'(dir_x), 1);

        do_load(1000, 500, 1, 0);
        chk("clamp_x", 32'(x), 632);
        chk("clamp_y", 32'(y), 472);

        resetn = 0; tick = 1; cyc(); resetn = 1; tick = 0;
        chk("mid_rst_x", 32'(x), 0);
        chk("mid_rst_run", 32'(running), 0);
        cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
